mdom_trigger_gen: RTL and testbench

- Parametrised next-generation trigger block for mDOM waveform acquisition. Sits between ADC/discriminator input pipeline and waveform buffer writer.
- Generalises sample width and discriminator channel count, and adds:
  - per-channel discriminator mask with multiplicity requirement;
  - minimum time-over-threshold qualification;
  - programmable post-trigger holdoff, enforced by an ARMED/HOLDOFF state machine.

---
 rtl/mdom_trig_pkg.sv | 16 +
 rtl/mdom_discr_mult.sv | 28 ++
 rtl/mdom_trigger_gen.sv | 195 +++++++++++++++++++
 tb/tb_mdom_trigger_gen.sv | 328 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdom_trig_pkg.sv
// Shared encodings for the mDOM trigger generator:
// trigger source codes and ARMED/HOLDOFF state encoding.
package mdom_trig_pkg;

    localparam logic [2:0] TRIG_SRC_NONE   = 3'd0;
    localparam logic [2:0] TRIG_SRC_SW     = 3'd1;
    localparam logic [2:0] TRIG_SRC_EXT    = 3'd2;
    localparam logic [2:0] TRIG_SRC_DISCR  = 3'd3;
    localparam logic [2:0] TRIG_SRC_THRESH = 3'd4;

    typedef enum logic {
        ST_ARMED   = 1'b0,
        ST_HOLDOFF = 1'b1
    } trig_state_t;

endpackage

// File: rtl/mdom_discr_mult.sv
// Discriminator multiplicity: polarity-corrected, masked channel
// count compared against the required multiplicity (0 acts as 1).
module mdom_discr_mult #(
    parameter int N_DISCR = 8,
    localparam int MW = $clog2(N_DISCR + 1)
) (
    input  logic [N_DISCR-1:0] discr,
    input  logic               pol,
    input  logic [N_DISCR-1:0] mask,
    input  logic [MW-1:0]      mult,
    output logic               hit
);

    logic [N_DISCR-1:0] active;
    logic [MW-1:0]      cnt;
    logic [MW-1:0]      need;

    always_comb begin
        active = ~(discr ^ {N_DISCR{pol}}) & mask;
        cnt    = '0;
        for (int i = 0; i < N_DISCR; i++) begin
            cnt = cnt + MW'(active[i]);
        end
        need = (mult == '0) ? MW'(1) : mult;
        hit  = (cnt >= need);
    end

endmodule

// File: rtl/mdom_trigger_gen.sv
// mDOM trigger generator: threshold/TOT, discriminator multiplicity,
// software and external triggers with holdoff. Option: MDOM_TRIG_VETO_CNT_EN.
module mdom_trigger_gen
    import mdom_trig_pkg::*;
#(
    parameter int ADC_W     = 12,
    parameter int N_DISCR   = 8,
    parameter int TOT_W     = 8,
    parameter int HOLDOFF_W = 16,
    localparam int MW = $clog2(N_DISCR + 1)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [ADC_W-1:0]     adc_stream_in,
    output logic [ADC_W-1:0]     adc_stream_out,
    input  logic [N_DISCR-1:0]   discr_stream_in,
    output logic [N_DISCR-1:0]   discr_stream_out,
    input  logic                 gt,
    input  logic                 et,
    input  logic                 lt,
    input  logic [ADC_W-1:0]     thr,
    input  logic                 thresh_trig_en,
    input  logic [TOT_W-1:0]     thresh_min_tot,
    input  logic                 run,
    input  logic                 ext_trig_en,
    input  logic                 ext_run,
    input  logic                 discr_trig_en,
    input  logic                 discr_trig_pol,
    input  logic [N_DISCR-1:0]   discr_mask,
    input  logic [MW-1:0]        discr_mult,
    input  logic [HOLDOFF_W-1:0] holdoff,
    output logic [2:0]           trig_src,
    output logic                 trig,
    output logic                 thresh_tot,
    output logic                 discr_tot,
    output logic                 armed
`ifdef MDOM_TRIG_VETO_CNT_EN
    ,
    output logic [15:0]          veto_cnt
`endif
);

    logic                 rst_q;
    logic                 run_q;
    logic                 ext_q;
    logic                 run_p;
    logic                 ext_p;
    logic                 cmp;
    logic                 i_discr;
    logic                 i_thresh_q;
    logic [TOT_W-1:0]     tot_cnt;
    logic [TOT_W:0]       tot_inc;
    logic [TOT_W:0]       tot_need;
    logic                 cand;
    logic [2:0]           cand_src;
    trig_state_t          state;
    trig_state_t          state_nx;
    logic [HOLDOFF_W-1:0] hcnt;
    logic [HOLDOFF_W-1:0] hcnt_nx;
    logic                 trig_nx;
    logic [2:0]           src_nx;

    always_ff @(posedge clk) begin
        rst_q <= rst;
    end

    always_ff @(posedge clk) begin
        if (rst_q) begin
            run_q <= 1'b0;
            ext_q <= 1'b0;
        end else begin
            run_q <= run;
            ext_q <= ext_run;
        end
    end

    assign run_p = run & ~run_q;
    assign ext_p = ext_run & ~ext_q;

    assign cmp = (gt && (adc_stream_in >  thr)) ||
                 (et && (adc_stream_in == thr)) ||
                 (lt && (adc_stream_in <  thr));

    mdom_discr_mult #(
        .N_DISCR (N_DISCR)
    ) u_discr_mult (
        .discr (discr_stream_in),
        .pol   (discr_trig_pol),
        .mask  (discr_mask),
        .mult  (discr_mult),
        .hit   (i_discr)
    );

    // One extra bit so a saturated count still compares correctly.
    assign tot_inc    = {1'b0, tot_cnt} + 1'b1;
    assign tot_need   = (thresh_min_tot == '0) ? (TOT_W+1)'(1)
                                               : {1'b0, thresh_min_tot};
    assign i_thresh_q = cmp && (tot_inc >= tot_need);

    always_ff @(posedge clk) begin
        if (rst_q || !cmp) begin
            tot_cnt <= '0;
        end else if (tot_cnt != '1) begin
            tot_cnt <= tot_cnt + 1'b1;
        end
    end

    always_comb begin
        cand     = 1'b1;
        cand_src = TRIG_SRC_NONE;
        if (ext_trig_en && ext_p) begin
            cand_src = TRIG_SRC_EXT;
        end else if (discr_trig_en && i_discr) begin
            cand_src = TRIG_SRC_DISCR;
        end else if (thresh_trig_en && i_thresh_q) begin
            cand_src = TRIG_SRC_THRESH;
        end else if (run_p) begin
            cand_src = TRIG_SRC_SW;
        end else begin
            cand = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_q) begin
            state <= ST_ARMED;
            hcnt  <= '0;
        end else begin
            state <= state_nx;
            hcnt  <= hcnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        hcnt_nx  = hcnt;
        trig_nx  = 1'b0;
        src_nx   = TRIG_SRC_NONE;
        case (state)
            ST_ARMED: begin
                if (cand) begin
                    trig_nx = 1'b1;
                    src_nx  = cand_src;
                    // Zero holdoff keeps the FSM armed every cycle.
                    if (holdoff != '0) begin
                        state_nx = ST_HOLDOFF;
                        hcnt_nx  = holdoff;
                    end
                end
            end
            ST_HOLDOFF: begin
                hcnt_nx = hcnt - 1'b1;
                if (hcnt <= HOLDOFF_W'(1)) begin
                    state_nx = ST_ARMED;
                    hcnt_nx  = '0;
                end
            end
            default: begin
                state_nx = ST_ARMED;
                hcnt_nx  = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst_q) begin
            adc_stream_out   <= '0;
            discr_stream_out <= '0;
            thresh_tot       <= 1'b0;
            discr_tot        <= 1'b0;
            trig             <= 1'b0;
            trig_src         <= TRIG_SRC_NONE;
        end else begin
            adc_stream_out   <= adc_stream_in;
            discr_stream_out <= discr_stream_in;
            thresh_tot       <= cmp;
            discr_tot        <= i_discr;
            trig             <= trig_nx;
            trig_src         <= src_nx;
        end
    end

    assign armed = (state == ST_ARMED);

`ifdef MDOM_TRIG_VETO_CNT_EN
    always_ff @(posedge clk) begin
        if (rst_q) begin
            veto_cnt <= '0;
        end else if (state == ST_HOLDOFF && cand && veto_cnt != 16'hFFFF) begin
            veto_cnt <= veto_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mdom_trigger_gen.sv
// Self-checking bench for mdom_trigger_gen: vector table, directed
// corner sequences and randomized run against a cycle-count model.
module tb_mdom_trigger_gen;

    localparam int ADC_W     = 12;
    localparam int N_DISCR   = 8;
    localparam int TOT_W     = 8;
    localparam int HOLDOFF_W = 16;
    localparam int MW        = $clog2(N_DISCR + 1);

    logic                 clk = 1'b0;
    logic                 rst;
    logic [ADC_W-1:0]     adc_stream_in;
    logic [ADC_W-1:0]     adc_stream_out;
    logic [N_DISCR-1:0]   discr_stream_in;
    logic [N_DISCR-1:0]   discr_stream_out;
    logic                 gt, et, lt;
    logic [ADC_W-1:0]     thr;
    logic                 thresh_trig_en;
    logic [TOT_W-1:0]     thresh_min_tot;
    logic                 run;
    logic                 ext_trig_en;
    logic                 ext_run;
    logic                 discr_trig_en;
    logic                 discr_trig_pol;
    logic [N_DISCR-1:0]   discr_mask;
    logic [MW-1:0]        discr_mult;
    logic [HOLDOFF_W-1:0] holdoff;
    logic [2:0]           trig_src;
    logic                 trig;
    logic                 thresh_tot;
    logic                 discr_tot;
    logic                 armed;
`ifdef MDOM_TRIG_VETO_CNT_EN
    logic [15:0]          veto_cnt;
`endif

    mdom_trigger_gen #(
        .ADC_W     (ADC_W),
        .N_DISCR   (N_DISCR),
        .TOT_W     (TOT_W),
        .HOLDOFF_W (HOLDOFF_W)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .adc_stream_in    (adc_stream_in),
        .adc_stream_out   (adc_stream_out),
        .discr_stream_in  (discr_stream_in),
        .discr_stream_out (discr_stream_out),
        .gt               (gt),
        .et               (et),
        .lt               (lt),
        .thr              (thr),
        .thresh_trig_en   (thresh_trig_en),
        .thresh_min_tot   (thresh_min_tot),
        .run              (run),
        .ext_trig_en      (ext_trig_en),
        .ext_run          (ext_run),
        .discr_trig_en    (discr_trig_en),
        .discr_trig_pol   (discr_trig_pol),
        .discr_mask       (discr_mask),
        .discr_mult       (discr_mult),
        .holdoff          (holdoff),
        .trig_src         (trig_src),
        .trig             (trig),
        .thresh_tot       (thresh_tot),
        .discr_tot        (discr_tot),
        .armed            (armed)
`ifdef MDOM_TRIG_VETO_CNT_EN
        ,
        .veto_cnt         (veto_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: absolute cycle number, first cycle at which triggering
    // is allowed again, current comparator run length, input history.
    longint m_cyc;
    longint m_next_ok;
    int     m_run_len;
    bit     m_prev_run;
    bit     m_prev_ext;
    int     m_veto;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc      = 0;
        m_next_ok  = 0;
        m_run_len  = 0;
        m_prev_run = 0;
        m_prev_ext = 0;
        m_veto     = 0;
    endtask

    task automatic idle_inputs();
        adc_stream_in   = '0;
        discr_stream_in = '0;
        gt = 0; et = 0; lt = 0;
        thr             = '0;
        thresh_trig_en  = 0;
        thresh_min_tot  = '0;
        run             = 0;
        ext_trig_en     = 0;
        ext_run         = 0;
        discr_trig_en   = 0;
        discr_trig_pol  = 0;
        discr_mask      = '0;
        discr_mult      = '0;
        holdoff         = '0;
    endtask

    // One clock: predict from the applied inputs, clock, compare all.
    task automatic tick();
        bit     cmp, dhit, qual, rp, ep, cand, armed_now, e_trig;
        int     pc, need, need_t;
        logic [2:0] src;
        int     e_adc, e_discr;
        cmp = (gt && adc_stream_in > thr) || (et && adc_stream_in == thr) ||
              (lt && adc_stream_in < thr);
        pc = 0;
        for (int i = 0; i < N_DISCR; i++)
            if (discr_mask[i] && (discr_stream_in[i] == discr_trig_pol)) pc++;
        need = (discr_mult == 0) ? 1 : int'(discr_mult);
        dhit = (pc >= need);
        need_t = (thresh_min_tot == 0) ? 1 : int'(thresh_min_tot);
        qual = cmp && (m_run_len + 1 >= need_t);
        rp = run && !m_prev_run;
        ep = ext_run && !m_prev_ext;
        cand = 1;
        if (ext_trig_en && ep)            src = 3'd2;
        else if (discr_trig_en && dhit)   src = 3'd3;
        else if (thresh_trig_en && qual)  src = 3'd4;
        else if (rp)                      src = 3'd1;
        else begin src = 3'd0; cand = 0; end
        armed_now = (m_cyc >= m_next_ok);
        e_trig = armed_now && cand;
        if (e_trig) m_next_ok = m_cyc + 1 + longint'(holdoff);
        else if (cand && m_veto < 65535) m_veto++;
        if (!e_trig) src = 3'd0;
        m_run_len  = cmp ? m_run_len + 1 : 0;
        m_prev_run = run;
        m_prev_ext = ext_run;
        m_cyc++;
        e_adc   = int'(adc_stream_in);
        e_discr = int'(discr_stream_in);
        @(posedge clk);
        #1;
        chk("adc_out",    32'(adc_stream_out),   32'(e_adc));
        chk("discr_out",  32'(discr_stream_out), 32'(e_discr));
        chk("thresh_tot", 32'(thresh_tot),       32'(cmp));
        chk("discr_tot",  32'(discr_tot),        32'(dhit));
        chk("trig",       32'(trig),             32'(e_trig));
        chk("trig_src",   32'(trig_src),         32'(src));
        chk("armed",      32'(armed),            32'(m_cyc >= m_next_ok));
`ifdef MDOM_TRIG_VETO_CNT_EN
        chk("veto_cnt",   32'(veto_cnt),         32'(m_veto));
`endif
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1;
        repeat (3) @(posedge clk);
        #1;
        rst = 0;
        @(posedge clk);
        #1;
        model_reset();
        chk("rst_trig",     32'(trig),           32'd0);
        chk("rst_src",      32'(trig_src),       32'd0);
        chk("rst_armed",    32'(armed),          32'd1);
        chk("rst_adc_out",  32'(adc_stream_out), 32'd0);
        chk("rst_dtot",     32'(discr_tot),      32'd0);
        chk("rst_ttot",     32'(thresh_tot),     32'd0);
`ifdef MDOM_TRIG_VETO_CNT_EN
        chk("rst_veto",     32'(veto_cnt),       32'd0);
`endif
    endtask

    typedef struct {
        logic                 pol;
        logic [N_DISCR-1:0]   mask;
        logic [MW-1:0]        mult;
        logic [N_DISCR-1:0]   discr;
        logic                 exp_hit;
    } dvec_t;

    dvec_t vecs [8];

    initial begin
        vecs[0] = '{1'b1, 8'h0F, 4'd2, 8'h11, 1'b0};
        vecs[1] = '{1'b1, 8'h0F, 4'd2, 8'h03, 1'b1};
        vecs[2] = '{1'b1, 8'h0F, 4'd0, 8'h01, 1'b1};
        vecs[3] = '{1'b1, 8'h00, 4'd0, 8'hFF, 1'b0};
        vecs[4] = '{1'b0, 8'hFF, 4'd4, 8'hF0, 1'b1};
        vecs[5] = '{1'b1, 8'hFF, 4'd8, 8'hFF, 1'b1};
        vecs[6] = '{1'b1, 8'hFF, 4'd8, 8'h7F, 1'b0};
        vecs[7] = '{1'b0, 8'h0F, 4'd1, 8'h0E, 1'b1};

        rst = 1;
        do_reset();

        // Threshold with minimum TOT of 3.
        thr = 12'd100; gt = 1; thresh_min_tot = 8'd3; thresh_trig_en = 1;
        adc_stream_in = 12'd101;
        tick(); chk("tot_s1", 32'(trig), 32'd0);
        tick(); chk("tot_s2", 32'(trig), 32'd0);
        tick(); chk("tot_s3", 32'(trig), 32'd1);
        chk("tot_src", 32'(trig_src), 32'd4);
        chk("tot_align", 32'(adc_stream_out), 32'd101);
        adc_stream_in = 12'd0; tick();
        adc_stream_in = 12'd101; tick(); chk("tot_b1", 32'(trig), 32'd0);
        tick(); chk("tot_b2", 32'(trig), 32'd0);
        adc_stream_in = 12'd50; tick(); chk("tot_b3", 32'(trig), 32'd0);

        // Discriminator multiplicity table.
        do_reset();
        discr_trig_en = 1;
        foreach (vecs[k]) begin
            discr_trig_pol  = vecs[k].pol;
            discr_mask      = vecs[k].mask;
            discr_mult      = vecs[k].mult;
            discr_stream_in = vecs[k].discr;
            tick();
            chk($sformatf("dvec%0d_trig", k), 32'(trig), 32'(vecs[k].exp_hit));
            chk($sformatf("dvec%0d_src", k), 32'(trig_src),
                vecs[k].exp_hit ? 32'd3 : 32'd0);
        end

        // Holdoff of 4 with a dropped run edge.
        do_reset();
        holdoff = 16'd4; ext_trig_en = 1; ext_run = 1;
        tick();
        chk("ho_trig", 32'(trig), 32'd1);
        chk("ho_src", 32'(trig_src), 32'd2);
        chk("ho_arm0", 32'(armed), 32'd0);
        run = 1;
        tick(); chk("ho_drop", 32'(trig), 32'd0);
        chk("ho_arm1", 32'(armed), 32'd0);
        tick(); chk("ho_arm2", 32'(armed), 32'd0);
        tick(); chk("ho_arm3", 32'(armed), 32'd0);
        tick(); chk("ho_rearm", 32'(armed), 32'd1);
        chk("ho_notrig", 32'(trig), 32'd0);
`ifdef MDOM_TRIG_VETO_CNT_EN
        chk("ho_veto", 32'(veto_cnt), 32'd1);
`endif
        run = 0; ext_run = 0; tick();
        ext_run = 1; tick();
        chk("ho_next", 32'(trig), 32'd1);

        // Priority among simultaneous candidates.
        do_reset();
        ext_trig_en = 1; discr_trig_en = 1; thresh_trig_en = 1;
        discr_trig_pol = 1; discr_mask = 8'hFF; discr_mult = 4'd1;
        thr = 12'd100; gt = 1; thresh_min_tot = 8'd1;
        tick();
        ext_run = 1; run = 1; discr_stream_in = 8'h01; adc_stream_in = 12'd200;
        tick(); chk("pri_ext", 32'(trig_src), 32'd2);
        ext_run = 0; run = 0; discr_stream_in = 8'h00; adc_stream_in = 12'd0;
        tick();
        ext_trig_en = 0;
        ext_run = 1; run = 1; discr_stream_in = 8'h01; adc_stream_in = 12'd200;
        tick(); chk("pri_discr", 32'(trig_src), 32'd3);

        // Reset in the middle of a long holdoff.
        do_reset();
        holdoff = 16'd1000; run = 1;
        tick(); chk("mr_trig", 32'(trig), 32'd1);
        run = 0; tick(); tick();
        chk("mr_hold", 32'(armed), 32'd0);
        do_reset();
        holdoff = 16'd1000;
        tick();
        run = 1; tick();
        chk("mr_sw", 32'(trig), 32'd1);
        chk("mr_src", 32'(trig_src), 32'd1);

        // Sustained threshold retriggers every cycle with zero holdoff.
        do_reset();
        thr = 12'd100; gt = 1; thresh_min_tot = 8'd1; thresh_trig_en = 1;
        adc_stream_in = 12'd300;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk($sformatf("sus%0d_trig", c), 32'(trig), 32'd1);
            chk($sformatf("sus%0d_tot", c), 32'(thresh_tot), 32'd1);
        end
        adc_stream_in = 12'd0; tick();
        chk("sus_end", 32'(trig), 32'd0);

        // Randomized run against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            if (c % 16 == 0) begin
                {gt, et, lt} = 3'($urandom_range(0, 7));
                thr            = 12'($urandom_range(95, 105));
                thresh_min_tot = 8'($urandom_range(0, 4));
                discr_trig_pol = 1'($urandom_range(0, 1));
                discr_mask     = 8'($urandom);
                discr_mult     = 4'($urandom_range(0, 6));
                thresh_trig_en = ($urandom_range(0, 3) != 0);
                discr_trig_en  = ($urandom_range(0, 3) == 0);
                ext_trig_en    = ($urandom_range(0, 1) == 0);
            end
            adc_stream_in   = 12'($urandom_range(90, 110));
            discr_stream_in = 8'($urandom);
            run             = ($urandom_range(0, 3) == 0);
            ext_run         = ($urandom_range(0, 3) == 0);
            holdoff         = 16'($urandom_range(0, 6));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
